// File: rtl/cp_dispatch_unit.sv
// ---------------------------------------------------------------------------
// cp_dispatch_unit
//
// Issues coprocessor instructions from the main core to a coprocessor
// decoder. Incoming 32-bit words are decoded for legality, illegal opcodes
// are dropped (with a one-cycle illegal_op pulse), and legal words are kept
// in program order in a small FIFO. The FIFO head is offered to the
// coprocessor over a valid/ready handshake. At most one memory-class op
// (load/store) may be outstanding: once one is issued, all further issue
// stalls until mem_done reports its completion.
//
// Optional feature (macro CP_DISPATCH_STATS_EN): adds two saturating 16-bit
// statistics counters, stat_issued and stat_stall.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid, in_instr   instruction from core ([31:26] opcode, [25:21] rs,
//                        [20:16] rt, [15:11] rd, [15:0] imm)
//   in_ready             unit can take in_instr this cycle
//   flush                synchronous pipeline flush (empties the FIFO)
//   cp_valid, cp_*       head instruction offered to the coprocessor
//   cp_ready             coprocessor accepts the head
//   mem_done             pulse: outstanding memory op has completed
//   illegal_op           pulse: an illegal opcode was dropped last cycle
//   busy                 FIFO non-empty or a memory op is pending
//   stat_issued          (CP_DISPATCH_STATS_EN) number of issued ops
//   stat_stall           (CP_DISPATCH_STATS_EN) cycles with input stalled
// ---------------------------------------------------------------------------
module cp_dispatch_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic        cp_valid,
    output logic [5:0]  cp_opcode,
    output logic [4:0]  cp_rs,
    output logic [4:0]  cp_rt,
    output logic [4:0]  cp_rd,
    output logic [15:0] cp_imm,
    input  logic        cp_ready,
    input  logic        mem_done,
    output logic        illegal_op,
`ifdef CP_DISPATCH_STATS_EN
    output logic [15:0] stat_issued,
    output logic [15:0] stat_stall,
`endif
    output logic        busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StMemWait
    } state_e;

    // -----------------------------------------------------------------------
    // Opcode classification
    // -----------------------------------------------------------------------
    function automatic logic is_legal(input logic [5:0] op);
        logic legal;
        legal = 1'b0;
        if (op[5:4] == 2'b10) begin
            legal = 1'b1;                  // ALU/immediate class
        end else if (op[5:4] == 2'b11 && op[3:0] <= 4'd4) begin
            legal = 1'b1;                  // non-memory 110000..110010, load, store
        end
        return legal;
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == 6'b110011) || (op == 6'b110100);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_e           state_q, state_d;
    logic             mem_pending_q, mem_pending_d;
    logic             illegal_q, illegal_d;

    logic             full;
    logic             accept;
    logic             push;
    logic             pop;
    logic [31:0]      head;

`ifdef CP_DISPATCH_STATS_EN
    logic [15:0]      stat_issued_q, stat_issued_d;
    logic [15:0]      stat_stall_q, stat_stall_d;
`endif

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        // No bypass while full: a same-cycle pop does not free a slot for input.
        in_ready = !full && !flush;
        accept   = in_valid && in_ready;
        push     = accept && is_legal(in_instr[31:26]);
        // StIssue is only ever entered with a non-empty FIFO.
        cp_valid = (state_q == StIssue) && !flush;
        pop      = cp_valid && cp_ready;
    end

    // Head fields are a pure function of stored state, so they hold steady
    // while the coprocessor back-pressures.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        cp_opcode = head[31:26];
        cp_rs     = head[25:21];
        cp_rt     = head[20:16];
        cp_rd     = head[15:11];
        cp_imm    = head[15:0];
    end

    // -----------------------------------------------------------------------
    // FIFO next state
    // -----------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_instr;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Issue FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        mem_pending_d = mem_pending_q;
        // Flush blocks acceptance, so no pulse can follow a flush cycle.
        illegal_d     = accept && !is_legal(in_instr[31:26]);

        unique case (state_q)
            StIdle: begin
                if (count_d != '0) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (pop && is_mem_op(head[31:26])) begin
                    mem_pending_d = 1'b1;
                    state_d       = StMemWait;
                end else if (count_d == '0) begin
                    state_d = StIdle;
                end
            end
            StMemWait: begin
                // Flush leaves this state alone: the in-flight op still completes.
                if (mem_done) begin
                    mem_pending_d = 1'b0;
                    state_d       = (count_d != '0) ? StIssue : StIdle;
                end
            end
            default: begin
                state_d       = StIdle;
                mem_pending_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= StIdle;
            mem_pending_q <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            mem_pending_q <= mem_pending_d;
            illegal_q     <= illegal_d;
        end
    end

    always_comb begin
        illegal_op = illegal_q;
        busy       = (count_q != '0) || mem_pending_q;
    end

    // -----------------------------------------------------------------------
    // Optional statistics
    // -----------------------------------------------------------------------
`ifdef CP_DISPATCH_STATS_EN
    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_stall_d  = stat_stall_q;
        if (pop && stat_issued_q != 16'hFFFF) begin
            stat_issued_d = stat_issued_q + 16'd1;
        end
        if (in_valid && !in_ready && stat_stall_q != 16'hFFFF) begin
            stat_stall_d = stat_stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_cp_dispatch_unit.sv
// ---------------------------------------------------------------------------
// tb_cp_dispatch_unit
//
// Self-checking bench for cp_dispatch_unit: a directed vector table, a few
// hand-written multi-cycle sequences (backpressure/full, flush, async reset)
// and a randomized phase, all checked against a queue-based reference model.
// Inputs are driven just after the falling edge; outputs are sampled 1 ns
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_cp_dispatch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        cp_valid;
    logic [5:0]  cp_opcode;
    logic [4:0]  cp_rs;
    logic [4:0]  cp_rt;
    logic [4:0]  cp_rd;
    logic [15:0] cp_imm;
    logic        cp_ready;
    logic        mem_done;
    logic        illegal_op;
    logic        busy;
`ifdef CP_DISPATCH_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_stall;
`endif

    cp_dispatch_unit #(
        .DEPTH(4),
        .CNT_W(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .flush      (flush),
        .cp_valid   (cp_valid),
        .cp_opcode  (cp_opcode),
        .cp_rs      (cp_rs),
        .cp_rt      (cp_rt),
        .cp_rd      (cp_rd),
        .cp_imm     (cp_imm),
        .cp_ready   (cp_ready),
        .mem_done   (mem_done),
        .illegal_op (illegal_op),
`ifdef CP_DISPATCH_STATS_EN
        .stat_issued(stat_issued),
        .stat_stall (stat_stall),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: program-ordered queue of accepted legal words plus an
    // "outstanding memory op" flag.
    logic [31:0] mq[$];
    bit          m_pend;
    bit          m_ill;
    bit          exp_rdy;
    bit          exp_cpv;
    int unsigned m_issued;
    int unsigned m_stall;

    function automatic bit is_legal(input logic [5:0] op);
        return (op >= 6'd32) && (op <= 6'd52);
    endfunction

    function automatic bit is_mem(input logic [5:0] op);
        return (op == 6'd51) || (op == 6'd52);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend   = 0;
        m_ill    = 0;
        m_issued = 0;
        m_stall  = 0;
    endtask

    // Apply inputs for one cycle and compare combinational outputs to the model.
    task automatic drive(input bit iv, input logic [5:0] op, input bit rdy, input bit fl,
                         input bit md);
        logic [31:0] w;
        logic [31:0] h;
        w        = $urandom();
        w[31:26] = op;
        in_valid = iv;
        in_instr = w;
        cp_ready = rdy;
        flush    = fl;
        mem_done = md;
        #1;
        exp_rdy = (mq.size() < DEPTH) && !fl;
        exp_cpv = (mq.size() != 0) && !m_pend && !fl;
        chk("m_in_ready", in_ready, exp_rdy);
        chk("m_cp_valid", cp_valid, exp_cpv);
        chk("m_busy", busy, (mq.size() != 0) || m_pend);
        chk("m_illegal_op", illegal_op, m_ill);
        if (exp_cpv) begin
            h = mq[0];
            chk("m_cp_opcode", cp_opcode, h[31:26]);
            chk("m_cp_rs", cp_rs, h[25:21]);
            chk("m_cp_rt", cp_rt, h[20:16]);
            chk("m_cp_rd", cp_rd, h[15:11]);
            chk("m_cp_imm", cp_imm, h[15:0]);
        end
    endtask

    // Advance one clock and update the model with the cycle's events.
    task automatic tick();
        bit          acc;
        bit          pop;
        logic [31:0] w;
        logic [31:0] h;
        w   = in_instr;
        acc = in_valid && exp_rdy;
        pop = exp_cpv && cp_ready;
        if (in_valid && !exp_rdy && m_stall < 65535) m_stall++;
        if (pop && m_issued < 65535) m_issued++;
        @(posedge clk);
        if (m_pend && mem_done) m_pend = 0;
        if (pop) begin
            h = mq.pop_front();
            if (is_mem(h[31:26])) m_pend = 1;
        end
        m_ill = acc && !is_legal(w[31:26]);
        if (acc && is_legal(w[31:26])) mq.push_back(w);
        if (flush) mq.delete();
        @(negedge clk);
    endtask

    typedef struct {
        bit         iv;
        logic [5:0] op;
        bit         rdy;
        bit         fl;
        bit         md;
        bit         e_cpv;
        bit         e_rdy;
        bit         e_busy;
        bit         e_ill;
        logic [5:0] e_op;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [5:0] exp_ops[5];
        logic [5:0] op;
        int unsigned r;

        // iv  op     rdy fl md | cpv rdy busy ill op
        tbl[0]  = '{1'b1, 6'h21, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00};
        tbl[1]  = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'h21};
        tbl[2]  = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00};
        tbl[3]  = '{1'b1, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00};
        tbl[4]  = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h00};
        tbl[5]  = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00};
        tbl[6]  = '{1'b1, 6'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00};
        tbl[7]  = '{1'b1, 6'h20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'h33};
        tbl[8]  = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00};
        tbl[9]  = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00};
        tbl[10] = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00};
        tbl[11] = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'h20};
        tbl[12] = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00};
        tbl[13] = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00};
        tbl[14] = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00};

        // Reset
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        cp_ready = 1'b0;
        flush    = 1'b0;
        mem_done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cp_valid", cp_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_illegal_op", illegal_op, 1'b0);
        chk("rst_cp_opcode", cp_opcode, 6'h00);
        chk("rst_cp_imm", cp_imm, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table: single issue, illegal drop, load + mem_done,
        // stray mem_done in idle.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].iv, tbl[i].op, tbl[i].rdy, tbl[i].fl, tbl[i].md);
            chk($sformatf("tbl%0d_cp_valid", i), cp_valid, tbl[i].e_cpv);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_illegal_op", i), illegal_op, tbl[i].e_ill);
            if (tbl[i].e_cpv) chk($sformatf("tbl%0d_cp_opcode", i), cp_opcode, tbl[i].e_op);
            tick();
        end

        // Fill to full under backpressure, then drain in order.
        for (int i = 0; i < 4; i++) begin
            op = 6'h20 + 6'(i);
            drive(1'b1, op, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 6'h24, 1'b0, 1'b0, 1'b0);
        chk("full_in_ready", in_ready, 1'b0);
        tick();
        drive(1'b1, 6'h24, 1'b1, 1'b0, 1'b0);
        chk("full_no_bypass", in_ready, 1'b0);
        chk("drain0_opcode", cp_opcode, 6'h20);
        tick();
        drive(1'b1, 6'h24, 1'b1, 1'b0, 1'b0);
        chk("fifth_accepted", in_ready, 1'b1);
        chk("drain1_opcode", cp_opcode, 6'h21);
        tick();
        exp_ops[2] = 6'h22;
        exp_ops[3] = 6'h23;
        exp_ops[4] = 6'h24;
        for (int i = 2; i < 5; i++) begin
            drive(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
            chk($sformatf("drain%0d_valid", i), cp_valid, 1'b1);
            chk($sformatf("drain%0d_opcode", i), cp_opcode, exp_ops[i]);
            tick();
        end
        drive(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
        chk("drained_busy", busy, 1'b0);
        tick();

        // Flush with 3 queued and a concurrent input.
        for (int i = 0; i < 3; i++) begin
            op = 6'h28 + 6'(i);
            drive(1'b1, op, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 6'h2B, 1'b1, 1'b1, 1'b0);
        chk("flush_in_ready", in_ready, 1'b0);
        chk("flush_cp_valid", cp_valid, 1'b0);
        tick();
        drive(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
        chk("post_flush_busy", busy, 1'b0);
        chk("post_flush_cp_valid", cp_valid, 1'b0);
        tick();

        // Flush while a load is outstanding: pending survives until mem_done.
        drive(1'b1, 6'h33, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 6'h20, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 6'h21, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 6'h00, 1'b1, 1'b1, 1'b0);
        chk("memwait_flush_cp_valid", cp_valid, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
            chk($sformatf("memwait_flush_busy%0d", i), busy, 1'b1);
            tick();
        end
        drive(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
        chk("memwait_done_busy", busy, 1'b0);
        tick();

        // Async reset during MEM_WAIT with two queued.
        drive(1'b1, 6'h34, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 6'h20, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 6'h21, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
        chk("pre_arst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_cp_valid", cp_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_illegal_op", illegal_op, 1'b0);
        chk("arst_cp_opcode", cp_opcode, 6'h00);
        chk("arst_cp_rd", cp_rd, 5'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
        chk("arst_late_done_busy", busy, 1'b0);
        chk("arst_late_done_valid", cp_valid, 1'b0);
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       op = 6'h20 + 6'($urandom_range(0, 15));
            else if (r < 6)  op = 6'h30 + 6'($urandom_range(0, 2));
            else if (r == 6) op = 6'h33;
            else if (r == 7) op = 6'h34;
            else             op = 6'($urandom_range(0, 63));
            drive($urandom_range(0, 9) < 6, op, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0);
            tick();
        end

`ifdef CP_DISPATCH_STATS_EN
        drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        chk("stat_issued", stat_issued, 16'(m_issued));
        chk("stat_stall", stat_stall, 16'(m_stall));
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
